// File: rtl/uart_pkg.sv
// Shared types and constants for the UART core: FSM state encodings,
// parity_mode encodings, parameter legality limits and parity helpers.
package uart_pkg;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_BREAK
   } rx_state_t;

   localparam logic [1:0] PAR_NONE     = 2'b00;
   localparam logic [1:0] PAR_EVEN     = 2'b01;
   localparam logic [1:0] PAR_ODD      = 2'b10;
   localparam logic [1:0] PAR_NONE_ALT = 2'b11;

   localparam int DATA_BITS_MIN  = 5;
   localparam int DATA_BITS_MAX  = 8;
   localparam int OVERSAMPLE_MIN = 4;

   // True when the mode inserts a parity bit into the frame.
   function automatic logic parity_enabled(input logic [1:0] mode);
      logic en;
      case (mode)
         PAR_EVEN, PAR_ODD:      en = 1'b1;
         PAR_NONE, PAR_NONE_ALT: en = 1'b0;
         default:                en = 1'b0;
      endcase
      return en;
   endfunction

   // Parity bit that makes (data ones + parity) even or odd; data must
   // already have its unused upper bits cleared.
   function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
      return (mode == PAR_ODD) ? ~(^data) : ^data;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: one s_tick every baud_div+1 clocks, shared by TX and RX.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DIV_W-1:0] baud_div,
   output logic             s_tick
);

   logic [DIV_W-1:0] count;

   // Comparing with >= lets a lowered divisor wrap at once instead of
   // running the counter all the way round.
   assign s_tick = (count >= baud_div);

   // Free-running divider counter, back to 0 on the tick cycle.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (reset)       count <= '0;
      else if (s_tick) count <= '0;
      else             count <= count + 1'b1;
   end

endmodule

// File: rtl/uart_core.sv
// UART core: oversampled TX and RX engines sharing one baud tick, with
// configurable data bits, parity and stop bits, and a one-word RX holding
// register with overrun detection.
module uart_core
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int DIV_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DIV_W-1:0] baud_div,
   input  logic [1:0]       parity_mode,
   input  logic             two_stop,
   input  logic [7:0]       tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             tx,
   output logic             tx_busy,
   input  logic             rx,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             rx_parity_err,
   output logic             rx_frame_err,
   output logic             rx_overrun
);

   localparam int                TICK_W    = $clog2(OVERSAMPLE);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);
   localparam logic [7:0]        DATA_MASK = 8'((1 << DATA_BITS) - 1);

   generate
      if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
         $error("uart_core: DATA_BITS must be in 5..8");
      end
      if (OVERSAMPLE < OVERSAMPLE_MIN || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
         $error("uart_core: OVERSAMPLE must be even and at least 4");
      end
   endgenerate

   logic s_tick;

   uart_baud_gen #(.DIV_W(DIV_W)) u_baud_gen (
      .clk      (clk),
      .reset    (reset),
      .baud_div (baud_div),
      .s_tick   (s_tick)
   );

   // ------------------------------------------------------------------ TX
   tx_state_t         tx_state, tx_next;
   logic [TICK_W-1:0] tx_tick_cnt;
   logic [2:0]        tx_bit_idx;
   logic              tx_stop_cnt;
   logic [7:0]        tx_shift;
   logic              tx_par_en, tx_par_bit, tx_two_stop;
   logic              tx_armed;     // holds tx_ready low until the first clk after reset
   logic              tx_accept, tx_bit_end;

   assign tx_accept  = tx_valid && tx_ready;
   assign tx_bit_end = s_tick && (tx_tick_cnt == TICK_LAST);

   // TX state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) tx_state <= TX_IDLE;
      else       tx_state <= tx_next;
   end

   // TX next-state: each non-idle state lasts OVERSAMPLE ticks per bit.
   always_comb begin
      // NOTE: default first so no path through the case leaves tx_next unassigned (no latch).
      tx_next = tx_state;
      case (tx_state)
         TX_IDLE:   if (tx_accept)  tx_next = TX_START;
         TX_START:  if (tx_bit_end) tx_next = TX_DATA;
         TX_DATA:   if (tx_bit_end && tx_bit_idx == BIT_LAST)
                       tx_next = tx_par_en ? TX_PARITY : TX_STOP;
         TX_PARITY: if (tx_bit_end) tx_next = TX_STOP;
         TX_STOP:   if (tx_bit_end && (!tx_two_stop || tx_stop_cnt))
                       tx_next = TX_IDLE;
         default:   tx_next = TX_IDLE;
      endcase
   end

   // TX outputs decoded from state.
   always_comb begin
      tx       = 1'b1;
      tx_ready = 1'b0;
      tx_busy  = 1'b1;
      case (tx_state)
         TX_IDLE: begin
            tx_ready = tx_armed;
            tx_busy  = 1'b0;
         end
         TX_START:  tx = 1'b0;
         TX_DATA:   tx = tx_shift[0];
         TX_PARITY: tx = tx_par_bit;
         TX_STOP:   tx = 1'b1;
         default:   tx_busy = 1'b0;
      endcase
   end

   // TX datapath: tick/bit counters, word and config capture, LSB-first shift.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_armed    <= 1'b0;
         tx_tick_cnt <= '0;
         tx_bit_idx  <= '0;
         tx_stop_cnt <= 1'b0;
         tx_shift    <= '0;
         tx_par_en   <= 1'b0;
         tx_par_bit  <= 1'b0;
         tx_two_stop <= 1'b0;
      end else begin
         tx_armed <= 1'b1;
         if (tx_state == TX_IDLE || tx_bit_end) tx_tick_cnt <= '0;
         else if (s_tick)                       tx_tick_cnt <= tx_tick_cnt + 1'b1;
         if (tx_accept) begin
            tx_shift    <= tx_data & DATA_MASK;
            tx_par_en   <= parity_enabled(parity_mode);
            tx_par_bit  <= parity_bit(tx_data & DATA_MASK, parity_mode);
            tx_two_stop <= two_stop;
            tx_bit_idx  <= '0;
            tx_stop_cnt <= 1'b0;
         end else if (tx_bit_end) begin
            if (tx_state == TX_DATA) begin
               tx_shift   <= tx_shift >> 1;
               tx_bit_idx <= tx_bit_idx + 1'b1;
            end
            if (tx_state == TX_STOP) tx_stop_cnt <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------ RX
   logic                 rx_meta, rx_sync;
   rx_state_t            rx_state, rx_next;
   logic [TICK_W-1:0]    rx_tick_cnt;
   logic [2:0]           rx_bit_idx;
   logic                 rx_stop_cnt;
   logic [DATA_BITS-1:0] rx_shift;
   logic [1:0]           rx_par_mode;
   logic                 rx_two_stop;
   logic                 rx_par_err_acc, rx_frame_err_acc;
   logic                 rx_sample, rx_frame_end, rx_frame_bad;
   logic                 rx_start_det, rx_handshake, rx_load;

   assign rx_start_det = (rx_state == RX_IDLE) && !rx_sync;
   assign rx_frame_bad = rx_frame_err_acc || !rx_sync;
   assign rx_handshake = rx_valid && rx_ready;
   assign rx_load      = rx_frame_end && (!rx_valid || rx_ready);

   // Two-flop synchroniser for the asynchronous line; resets to idle-high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   // RX state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rx_state <= RX_IDLE;
      else       rx_state <= rx_next;
   end

   // RX next-state: half-bit start qualification, then one sample per bit.
   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE:   if (!rx_sync)  rx_next = RX_START;
         RX_START:  if (rx_sample) rx_next = rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:   if (rx_sample && rx_bit_idx == BIT_LAST)
                       rx_next = parity_enabled(rx_par_mode) ? RX_PARITY : RX_STOP;
         RX_PARITY: if (rx_sample) rx_next = RX_STOP;
         RX_STOP:   if (rx_frame_end) rx_next = rx_frame_bad ? RX_BREAK : RX_IDLE;
         RX_BREAK:  if (rx_sync)   rx_next = RX_IDLE;
         default:   rx_next = RX_IDLE;
      endcase
   end

   // RX strobes: mid-bit sample point and end-of-frame.
   always_comb begin
      rx_sample    = 1'b0;
      rx_frame_end = 1'b0;
      case (rx_state)
         RX_START:           rx_sample = s_tick && (rx_tick_cnt == TICK_HALF);
         RX_DATA, RX_PARITY: rx_sample = s_tick && (rx_tick_cnt == TICK_LAST);
         RX_STOP: begin
            rx_sample    = s_tick && (rx_tick_cnt == TICK_LAST);
            rx_frame_end = s_tick && (rx_tick_cnt == TICK_LAST) &&
                           (!rx_two_stop || rx_stop_cnt);
         end
         default: ;
      endcase
   end

   // RX datapath: tick/bit counters, config capture, shift-in and per-word error accumulation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_tick_cnt      <= '0;
         rx_bit_idx       <= '0;
         rx_stop_cnt      <= 1'b0;
         rx_shift         <= '0;
         rx_par_mode      <= PAR_NONE;
         rx_two_stop      <= 1'b0;
         rx_par_err_acc   <= 1'b0;
         rx_frame_err_acc <= 1'b0;
      end else begin
         if (rx_state == RX_IDLE || rx_state == RX_BREAK || rx_sample) rx_tick_cnt <= '0;
         else if (s_tick)                                              rx_tick_cnt <= rx_tick_cnt + 1'b1;
         if (rx_start_det) begin
            rx_par_mode      <= parity_mode;
            rx_two_stop      <= two_stop;
            rx_bit_idx       <= '0;
            rx_stop_cnt      <= 1'b0;
            rx_par_err_acc   <= 1'b0;
            rx_frame_err_acc <= 1'b0;
         end else if (rx_sample) begin
            case (rx_state)
               RX_DATA: begin
                  rx_shift   <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                  rx_bit_idx <= rx_bit_idx + 1'b1;
               end
               RX_PARITY: rx_par_err_acc <= (rx_sync != parity_bit(8'(rx_shift), rx_par_mode));
               RX_STOP: begin
                  rx_stop_cnt <= 1'b1;
                  if (!rx_sync) rx_frame_err_acc <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   // RX holding register: load on free slot, flag overrun otherwise, clear on handshake.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_valid      <= 1'b0;
         rx_data       <= '0;
         rx_parity_err <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_overrun    <= 1'b0;
      end else begin
         if (rx_load) begin
            rx_valid      <= 1'b1;
            rx_data       <= 8'(rx_shift);
            rx_parity_err <= rx_par_err_acc;
            rx_frame_err  <= rx_frame_bad;
         end else if (rx_handshake) begin
            rx_valid <= 1'b0;
         end
         if (rx_frame_end && rx_valid && !rx_ready) rx_overrun <= 1'b1;
         else if (rx_handshake)                     rx_overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_core.sv
// Directed self-checking bench for uart_core (8 data bits, 16x oversample,
// baud_div=3 so one bit lasts 64 clk).
module tb_uart_core;

   localparam int BIT_CLK = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] baud_div;
   logic [1:0]  parity_mode;
   logic        two_stop;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        tx;
   logic        tx_busy;
   logic        rx;
   logic        rx_line;
   logic        loop_en;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        rx_parity_err;
   logic        rx_frame_err;
   logic        rx_overrun;

   int n_checks = 0;
   int n_fail   = 0;

   assign rx = loop_en ? tx : rx_line;

   uart_core #(.DATA_BITS(8), .OVERSAMPLE(16), .DIV_W(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .baud_div      (baud_div),
      .parity_mode   (parity_mode),
      .two_stop      (two_stop),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .tx            (tx),
      .tx_busy       (tx_busy),
      .rx            (rx),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .rx_parity_err (rx_parity_err),
      .rx_frame_err  (rx_frame_err),
      .rx_overrun    (rx_overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Waits (bounded) for tx_ready, then presents one word; returns just after the accepting edge.
   task automatic tx_accept(input logic [7:0] data, input string tag);
      int waited = 0;
      @(negedge clk);
      while (!tx_ready && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      check({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
      tx_data  = data;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
   endtask

   // Samples tx at each bit centre after acceptance, then times the return of tx_ready.
   // The free-running tick phase can shorten the start bit by up to 3 clk.
   task automatic tx_check_frame(input int nbits, input logic [11:0] exp_bits, input string tag);
      int  elapsed;
      logic in_win;
      repeat (BIT_CLK / 2) @(posedge clk);
      elapsed = BIT_CLK / 2;
      for (int i = 0; i < nbits; i++) begin
         if (i > 0) begin
            repeat (BIT_CLK) @(posedge clk);
            elapsed += BIT_CLK;
         end
         #1;
         check($sformatf("%s_bit%0d", tag, i), 32'(tx), 32'(exp_bits[i]));
      end
      check({tag, "_busy_in_stop"}, 32'(tx_busy), 32'd1);
      while (!tx_ready && elapsed < nbits * BIT_CLK + 16) begin
         @(posedge clk);
         #1;
         elapsed++;
      end
      in_win = (elapsed >= nbits * BIT_CLK - 3) && (elapsed <= nbits * BIT_CLK);
      check($sformatf("%s_ready_after_clk_%0d", tag, elapsed), 32'(in_win), 32'd1);
   endtask

   // Drives one frame onto rx_line: start, 8 data bits LSB first, optional parity, one stop.
   task automatic rx_send(input logic [7:0] data, input logic use_par, input logic par_val,
                          input logic stop_val);
      @(negedge clk);
      rx_line = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_line = data[i];
         repeat (BIT_CLK) @(negedge clk);
      end
      if (use_par) begin
         rx_line = par_val;
         repeat (BIT_CLK) @(negedge clk);
      end
      rx_line = stop_val;
      repeat (BIT_CLK) @(negedge clk);
   endtask

   task automatic wait_rx_valid(input string tag);
      int waited = 0;
      while (!rx_valid && waited < 1000) begin
         @(negedge clk);
         waited++;
      end
      check({tag, "_rx_valid"}, 32'(rx_valid), 32'd1);
   endtask

   // One-cycle rx_ready pulse; the held word must be released.
   task automatic rx_take(input string tag);
      @(negedge clk);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      check({tag, "_valid_cleared"}, 32'(rx_valid), 32'd0);
   endtask

   initial begin
      #(10 * 60000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      baud_div    = 16'd3;
      parity_mode = 2'b00;
      two_stop    = 1'b0;
      tx_data     = 8'h00;
      tx_valid    = 1'b0;
      rx_line     = 1'b1;
      loop_en     = 1'b0;
      rx_ready    = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_tx",        32'(tx),            32'd1);
      check("rst_tx_ready",  32'(tx_ready),      32'd0);
      check("rst_tx_busy",   32'(tx_busy),       32'd0);
      check("rst_rx_valid",  32'(rx_valid),      32'd0);
      check("rst_rx_data",   32'(rx_data),       32'd0);
      check("rst_par_err",   32'(rx_parity_err), 32'd0);
      check("rst_frame_err", 32'(rx_frame_err),  32'd0);
      check("rst_overrun",   32'(rx_overrun),    32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("rst_ready_first_clk", 32'(tx_ready), 32'd1);

      // Scenario 1: 8N1 0xA5 -> 0,1,0,1,0,0,1,0,1,1
      tx_accept(8'hA5, "s1");
      tx_check_frame(10, 12'b0011_0100_1010, "s1");

      // Scenario 2: loopback, odd parity, two stop bits, 0x3C (four ones -> parity 1)
      loop_en     = 1'b1;
      parity_mode = 2'b10;
      two_stop    = 1'b1;
      tx_accept(8'h3C, "s2");
      tx_check_frame(12, 12'b1110_0111_1000, "s2");
      wait_rx_valid("s2");
      check("s2_rx_data",   32'(rx_data),       32'h3C);
      check("s2_par_err",   32'(rx_parity_err), 32'd0);
      check("s2_frame_err", 32'(rx_frame_err),  32'd0);
      rx_take("s2");
      loop_en     = 1'b0;
      parity_mode = 2'b00;
      two_stop    = 1'b0;

      // Even parity, 0x03 sent with parity bit 1 (correct bit is 0)
      parity_mode = 2'b01;
      rx_send(8'h03, 1'b1, 1'b1, 1'b1);
      wait_rx_valid("par");
      check("par_rx_data",   32'(rx_data),       32'h03);
      check("par_par_err",   32'(rx_parity_err), 32'd1);
      check("par_frame_err", 32'(rx_frame_err),  32'd0);
      rx_take("par");
      parity_mode = 2'b00;

      // Scenario 3: 0x55 with stop forced low, line low for 3 bit periods
      rx_send(8'h55, 1'b0, 1'b0, 1'b0);
      wait_rx_valid("s3");
      check("s3_rx_data",   32'(rx_data),       32'h55);
      check("s3_frame_err", 32'(rx_frame_err),  32'd1);
      check("s3_par_err",   32'(rx_parity_err), 32'd0);
      rx_take("s3");
      repeat (2 * BIT_CLK - 4) @(negedge clk);
      rx_line = 1'b1;
      repeat (10 * BIT_CLK) @(negedge clk);
      check("s3_no_second_frame", 32'(rx_valid), 32'd0);

      // Scenario 4: overrun with rx_ready held low
      rx_send(8'h11, 1'b0, 1'b0, 1'b1);
      wait_rx_valid("s4a");
      check("s4_first_data", 32'(rx_data), 32'h11);
      rx_send(8'h22, 1'b0, 1'b0, 1'b1);
      repeat (8) @(negedge clk);
      check("s4_kept_data",  32'(rx_data),      32'h11);
      check("s4_overrun",    32'(rx_overrun),   32'd1);
      check("s4_still_valid",32'(rx_valid),     32'd1);
      check("s4_frame_err",  32'(rx_frame_err), 32'd0);
      rx_take("s4");
      check("s4_overrun_cleared", 32'(rx_overrun), 32'd0);

      // Scenario 5: 16 clk low glitch
      @(negedge clk);
      rx_line = 1'b0;
      repeat (16) @(negedge clk);
      rx_line = 1'b1;
      repeat (12 * BIT_CLK) @(negedge clk);
      check("s5_no_valid",  32'(rx_valid),      32'd0);
      check("s5_frame_err", 32'(rx_frame_err),  32'd0);
      check("s5_par_err",   32'(rx_parity_err), 32'd0);
      check("s5_overrun",   32'(rx_overrun),    32'd0);

      // Scenario 6: reset in the middle of TX DATA, then a clean 0x0F
      tx_accept(8'h00, "s6a");
      repeat (3 * BIT_CLK) @(negedge clk);
      check("s6_tx_low_in_data", 32'(tx), 32'd0);
      #2;
      reset = 1'b1;
      #1;
      check("s6_async_tx",       32'(tx),       32'd1);
      check("s6_async_tx_ready", 32'(tx_ready), 32'd0);
      check("s6_async_tx_busy",  32'(tx_busy),  32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("s6_ready_after_release", 32'(tx_ready), 32'd1);
      tx_accept(8'h0F, "s6b");
      tx_check_frame(10, 12'b0010_0001_1110, "s6b");
      check("s6_rx_valid", 32'(rx_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
